// File: rtl/pcs_rx_deskew.sv
// Multi-lane PCS receive deskew: per-lane skew FIFOs aligned on alignment markers, rows reordered by lane ID.
// Build option: define PCS_RX_DESKEW_AM_REMOVE_EN to consume marker rows without presenting them on the output.
module pcs_rx_deskew #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66,
    parameter int DEPTH   = 32,
    localparam int LANE_ID_W = (LANE_N > 1) ? $clog2(LANE_N) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LANE_N-1:0]            valid_i,
    input  logic [LANE_N*BLOCK_W-1:0]    block_i,
    input  logic [LANE_N-1:0]            am_v_i,
    input  logic [LANE_N-1:0]            am_lock_i,
    input  logic [LANE_N*LANE_ID_W-1:0]  lane_id_i,
    output logic                         valid_o,
    output logic [LANE_N*BLOCK_W-1:0]    block_o,
    output logic                         am_v_o,
    output logic                         lock_o,
    output logic                         skew_err_o
);

    localparam int          AW = $clog2(DEPTH);
    localparam int          PW = AW + 1;
    localparam int unsigned LN = LANE_N;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_LOCKED
    } state_t;

    state_t                 r_state;
    logic [BLOCK_W:0]       r_mem [LANE_N][DEPTH];
    logic [PW-1:0]          r_wr_ptr [LANE_N];
    logic [PW-1:0]          r_rd_ptr [LANE_N];
    logic [LANE_N-1:0]      r_seen;
    logic [LANE_ID_W-1:0]   r_map [LANE_N];

    logic                   r_valid_o;
    logic [LANE_N*BLOCK_W-1:0] r_block_o;
    logic                   r_am_v_o;
    logic                   r_lock_o;
    logic                   r_skew_err_o;

    logic                   w_active;
    logic                   w_lost;
    logic [LANE_N-1:0]      w_empty;
    logic [LANE_N-1:0]      w_full;
    logic [LANE_N-1:0]      w_base_wr;
    logic [LANE_N-1:0]      w_first_am;
    logic [LANE_N-1:0]      w_ovf;
    logic [LANE_N-1:0]      w_row_am;
    logic [LANE_N-1:0]      w_seen_next;
    logic [LANE_N-1:0]      w_keep_am;
    logic [LANE_N-1:0]      w_wr;
    logic [LANE_ID_W-1:0]   w_map_next [LANE_N];
    logic [BLOCK_W-1:0]     w_row [LANE_N];
    logic                   w_rd;
    logic                   w_map_ok;
    logic                   w_map_bad;
    logic                   w_mixed;
    logic                   w_err;
    logic                   w_flush;
    logic                   w_row_ok;
    logic                   w_out_valid;
    logic                   w_out_am;
    logic [LANE_N*BLOCK_W-1:0] w_ord;
    state_t                 w_state_next;

    always_comb begin
        w_active = (r_state != S_IDLE);
        w_lost   = w_active & ~(&am_lock_i);

        for (int unsigned p = 0; p < LN; p++) begin
            w_empty[p]    = (r_wr_ptr[p] == r_rd_ptr[p]);
            w_full[p]     = ((r_wr_ptr[p] - r_rd_ptr[p]) == PW'(DEPTH));
            w_row[p]      = r_mem[p][r_rd_ptr[p][AW-1:0]][BLOCK_W-1:0];
            w_row_am[p]   = r_mem[p][r_rd_ptr[p][AW-1:0]][BLOCK_W];
            w_base_wr[p]  = w_active & valid_i[p] & (r_seen[p] | am_v_i[p]);
            w_first_am[p] = w_active & valid_i[p] & am_v_i[p] & ~r_seen[p];
            w_map_next[p] = w_first_am[p] ? lane_id_i[p*LANE_ID_W +: LANE_ID_W] : r_map[p];
        end

        w_rd = (r_state == S_LOCKED) & ~(|w_empty);

        for (int unsigned p = 0; p < LN; p++) begin
            w_ovf[p] = w_base_wr[p] & w_full[p] & ~w_rd;
        end

        w_seen_next = r_seen | w_first_am;

        // Lane map must be a permutation of 0..LANE_N-1.
        w_map_ok = 1'b1;
        for (int unsigned p = 0; p < LN; p++) begin
            if (32'(w_map_next[p]) >= LN) begin
                w_map_ok = 1'b0;
            end
            for (int unsigned q = p + 1; q < LN; q++) begin
                if (w_map_next[p] == w_map_next[q]) begin
                    w_map_ok = 1'b0;
                end
            end
        end

        w_map_bad = (r_state == S_ALIGN) & (&w_seen_next) & ~w_map_ok;
        w_mixed   = w_rd & (|w_row_am) & ~(&w_row_am);
        w_err     = ~w_lost & ((|w_ovf) | w_map_bad | w_mixed);
        w_flush   = (r_state == S_IDLE) | w_lost | w_err;

        // After an error flush, a fresh AM restarts its lane; the markers that just failed the map check do not.
        for (int unsigned p = 0; p < LN; p++) begin
            w_keep_am[p] = valid_i[p] & am_v_i[p] & ~w_ovf[p] & ~w_map_bad;
            w_wr[p]      = w_flush ? (w_err & w_keep_am[p]) : w_base_wr[p];
        end

        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (&am_lock_i) begin
                    w_state_next = S_ALIGN;
                end
            end
            default: begin
                if (w_lost) begin
                    w_state_next = S_IDLE;
                end else if (w_err) begin
                    w_state_next = S_ALIGN;
                end else if ((r_state == S_ALIGN) && (&w_seen_next)) begin
                    w_state_next = S_LOCKED;
                end
            end
        endcase

        w_ord = '0;
        for (int unsigned k = 0; k < LN; k++) begin
            for (int unsigned p = 0; p < LN; p++) begin
                if (r_map[p] == LANE_ID_W'(k)) begin
                    w_ord[k*BLOCK_W +: BLOCK_W] = w_row[p];
                end
            end
        end

        w_row_ok = w_rd & ~w_flush;
`ifdef PCS_RX_DESKEW_AM_REMOVE_EN
        w_out_valid = w_row_ok & ~(&w_row_am);
        w_out_am    = 1'b0;
`else
        w_out_valid = w_row_ok;
        w_out_am    = w_row_ok & (&w_row_am);
`endif
    end

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < LN; p++) begin
            if (w_wr[p]) begin
                r_mem[p][w_flush ? AW'(0) : r_wr_ptr[p][AW-1:0]] <= {am_v_i[p], block_i[p*BLOCK_W +: BLOCK_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_seen       <= '0;
            r_valid_o    <= 1'b0;
            r_block_o    <= '0;
            r_am_v_o     <= 1'b0;
            r_lock_o     <= 1'b0;
            r_skew_err_o <= 1'b0;
            for (int unsigned p = 0; p < LN; p++) begin
                r_wr_ptr[p] <= '0;
                r_rd_ptr[p] <= '0;
                r_map[p]    <= '0;
            end
        end else begin
            r_state <= w_state_next;
            for (int unsigned p = 0; p < LN; p++) begin
                if (w_flush) begin
                    r_rd_ptr[p] <= '0;
                    r_wr_ptr[p] <= w_wr[p] ? PW'(1) : '0;
                    r_seen[p]   <= w_wr[p];
                    if (w_wr[p]) begin
                        r_map[p] <= lane_id_i[p*LANE_ID_W +: LANE_ID_W];
                    end
                end else begin
                    if (w_wr[p]) begin
                        r_wr_ptr[p] <= r_wr_ptr[p] + PW'(1);
                    end
                    if (w_rd) begin
                        r_rd_ptr[p] <= r_rd_ptr[p] + PW'(1);
                    end
                    r_seen[p] <= w_seen_next[p];
                    r_map[p]  <= w_map_next[p];
                end
            end
            r_valid_o    <= w_out_valid;
            r_am_v_o     <= w_out_am;
            r_lock_o     <= (w_state_next == S_LOCKED);
            r_skew_err_o <= w_err;
            if (w_row_ok) begin
                r_block_o <= w_ord;
            end
        end
    end

    assign valid_o    = r_valid_o;
    assign block_o    = r_block_o;
    assign am_v_o     = r_am_v_o;
    assign lock_o     = r_lock_o;
    assign skew_err_o = r_skew_err_o;

endmodule
